io_dev_ctrl: RTL and testbench

//   Memory-mapped peripheral controller on the IO-bus device side (0xFFFFF000-0xFFFFFFFF).

---
 rtl/io_dev_ctrl_if.sv | 18 +
 rtl/io_dev_ctrl.sv | 134 +++++++++++++
 tb/tb_io_dev_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/io_dev_ctrl_if.sv
// IO-bus device-side interface: address, write data, enables and read data.
interface io_dev_ctrl_if;
    logic [11:0] dv_addr;
    logic [31:0] dv_wr_data;
    logic        dv_wr_e;
    logic        dv_rd_e;
    logic [31:0] dv_rd_data;

    modport master (
        output dv_addr, dv_wr_data, dv_wr_e, dv_rd_e,
        input  dv_rd_data
    );

    modport slave (
        input  dv_addr, dv_wr_data, dv_wr_e, dv_rd_e,
        output dv_rd_data
    );
endinterface

// File: rtl/io_dev_ctrl.sv
// Memory-mapped peripheral controller: 8-digit multiplexed 7-segment display,
// LED bank and synchronised switch inputs behind a 12-bit register window.
module io_dev_ctrl #(
    parameter int SCAN_DIV = 20000,
    parameter int SW_W     = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    io_dev_ctrl_if.slave    bus,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] led,
    output logic [7:0]      dig_en,
    output logic [7:0]      seg
);

    localparam logic [11:0] ADDR_DIG  = 12'h000;
    localparam logic [11:0] ADDR_MASK = 12'h004;
    localparam logic [11:0] ADDR_LED  = 12'h060;
    localparam logic [11:0] ADDR_SW   = 12'h070;

    localparam int              CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      dig_q;
    logic [7:0]       mask_q;
    logic [SW_W-1:0]  led_q;
    logic [SW_W-1:0]  s1_q;
    logic [SW_W-1:0]  s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       dig_en_q;
    logic [7:0]       seg_q;

    logic             cnt_wrap;
    logic [2:0]       idx_next;
    logic [3:0]       nibble_next;
    logic [7:0]       dig_en_next;
    logic [7:0]       seg_next;

    // Active-low hex decode, dp (bit 7) always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 8'hC0;
            4'h1: hex_to_seg = 8'hF9;
            4'h2: hex_to_seg = 8'hA4;
            4'h3: hex_to_seg = 8'hB0;
            4'h4: hex_to_seg = 8'h99;
            4'h5: hex_to_seg = 8'h92;
            4'h6: hex_to_seg = 8'h82;
            4'h7: hex_to_seg = 8'hF8;
            4'h8: hex_to_seg = 8'h80;
            4'h9: hex_to_seg = 8'h90;
            4'hA: hex_to_seg = 8'h88;
            4'hB: hex_to_seg = 8'h83;
            4'hC: hex_to_seg = 8'hC6;
            4'hD: hex_to_seg = 8'hA1;
            4'hE: hex_to_seg = 8'h86;
            default: hex_to_seg = 8'h8E;
        endcase
    endfunction

    // Register writes from the bus; unmapped and read-only addresses are ignored.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q  <= '0;
            mask_q <= 8'hFF;
            led_q  <= '0;
        end else if (bus.dv_wr_e) begin
            case (bus.dv_addr)
                ADDR_DIG:  dig_q  <= bus.dv_wr_data;
                ADDR_MASK: mask_q <= bus.dv_wr_data[7:0];
                ADDR_LED:  led_q  <= bus.dv_wr_data[SW_W-1:0];
                default:   ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= sw;
            s2_q <= s1_q;
        end
    end

    // Next digit selection; outputs are built from the post-edge index so that
    // enable and segments always belong to the same digit.
    always_comb begin
        cnt_wrap    = (cnt_q == CNT_LAST);
        idx_next    = cnt_wrap ? idx_q + 3'd1 : idx_q;
        nibble_next = dig_q[{idx_next, 2'b00} +: 4];
        dig_en_next = mask_q[idx_next] ? ~(8'b1 << idx_next) : 8'hFF;
        seg_next    = hex_to_seg(nibble_next);
    end

    // Scan counter, digit index and registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            dig_en_q <= 8'hFE;
            seg_q    <= 8'hC0;
        end else begin
            cnt_q    <= cnt_wrap ? '0 : cnt_q + 1'b1;
            idx_q    <= idx_next;
            dig_en_q <= dig_en_next;
            seg_q    <= seg_next;
        end
    end

    // Zero-latency read mux; unmapped addresses and idle cycles return zero.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        bus.dv_rd_data = 32'h0;
        if (bus.dv_rd_e) begin
            case (bus.dv_addr)
                ADDR_DIG:  bus.dv_rd_data = dig_q;
                ADDR_MASK: bus.dv_rd_data = {24'h0, mask_q};
                ADDR_LED:  bus.dv_rd_data = 32'(led_q);
                ADDR_SW:   bus.dv_rd_data = 32'(s2_q);
                default:   bus.dv_rd_data = 32'h0;
            endcase
        end
    end

    assign led    = led_q;
    assign dig_en = dig_en_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_io_dev_ctrl.sv
// Directed self-checking bench for io_dev_ctrl with a short scan period.
module tb_io_dev_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int SW_W     = 24;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SW_W-1:0] sw = '0;
    logic [SW_W-1:0] led;
    logic [7:0]      dig_en;
    logic [7:0]      seg;

    io_dev_ctrl_if bus ();

    io_dev_ctrl #(.SCAN_DIV(SCAN_DIV), .SW_W(SW_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .sw     (sw),
        .led    (led),
        .dig_en (dig_en),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the writable registers and scan position.
    logic [31:0] m_dig  = 32'h0;
    logic [7:0]  m_mask = 8'hFF;
    int          cyc    = 0;
    logic [7:0]  exp_en  = 8'hFE;
    logic [7:0]  exp_seg = 8'hC0;

    function automatic logic [7:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 8'hC0;  4'h1: seg_of = 8'hF9;
            4'h2: seg_of = 8'hA4;  4'h3: seg_of = 8'hB0;
            4'h4: seg_of = 8'h99;  4'h5: seg_of = 8'h92;
            4'h6: seg_of = 8'h82;  4'h7: seg_of = 8'hF8;
            4'h8: seg_of = 8'h80;  4'h9: seg_of = 8'h90;
            4'hA: seg_of = 8'h88;  4'hB: seg_of = 8'h83;
            4'hC: seg_of = 8'hC6;  4'hD: seg_of = 8'hA1;
            4'hE: seg_of = 8'h86;  default: seg_of = 8'h8E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: update model from any pending write, advance, then check scan outputs.
    task automatic tick();
        logic [31:0] pd;
        logic [7:0]  pm;
        int          i;
        pd = m_dig;
        pm = m_mask;
        if (bus.dv_wr_e) begin
            if (bus.dv_addr == 12'h000) m_dig  = bus.dv_wr_data;
            if (bus.dv_addr == 12'h004) m_mask = bus.dv_wr_data[7:0];
        end
        @(posedge clk);
        #1;
        cyc++;
        i = (cyc / SCAN_DIV) % 8;
        exp_en  = pm[i] ? ~(8'b1 << i) : 8'hFF;
        exp_seg = seg_of(pd[4*i +: 4]);
        check("dig_en", {24'h0, dig_en}, {24'h0, exp_en});
        check("seg", {24'h0, seg}, {24'h0, exp_seg});
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        bus.dv_addr    = a;
        bus.dv_wr_data = d;
        bus.dv_wr_e    = 1'b1;
        tick();
        bus.dv_wr_e    = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.dv_addr = a;
        bus.dv_rd_e = 1'b1;
        #1;
        check(tag, bus.dv_rd_data, exp);
        bus.dv_rd_e = 1'b0;
    endtask

    initial begin
        bus.dv_addr    = '0;
        bus.dv_wr_data = '0;
        bus.dv_wr_e    = 1'b0;
        bus.dv_rd_e    = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_dig_en", {24'h0, dig_en}, 32'hFE);
        check("rst_seg", {24'h0, seg}, 32'hC0);
        bus_read("rst_rd_dig", 12'h000, 32'h0);
        bus_read("rst_rd_mask", 12'h004, 32'hFF);
        bus_read("rst_rd_led", 12'h060, 32'h0);
        bus_read("rst_rd_sw", 12'h070, 32'h0);
        rst_n = 1'b1;

        // Scan through all eight digits and wrap.
        bus_write(12'h000, 32'h1234ABCD);
        repeat (35) tick();
        bus_read("rd_dig", 12'h000, 32'h1234ABCD);

        // LED write with a same-cycle read returning the old value.
        bus.dv_addr    = 12'h060;
        bus.dv_wr_data = 32'hFFFFFFFF;
        bus.dv_wr_e    = 1'b1;
        bus.dv_rd_e    = 1'b1;
        #1;
        check("led_rd_pre_write", bus.dv_rd_data, 32'h0);
        tick();
        bus.dv_wr_e = 1'b0;
        bus.dv_rd_e = 1'b0;
        check("led_out", 32'(led), 32'h00FFFFFF);
        bus_read("rd_led", 12'h060, 32'h00FFFFFF);

        // Switch synchroniser latency.
        sw = 24'h5A5A5A;
        bus_read("sw_lat0", 12'h070, 32'h0);
        tick();
        bus_read("sw_lat1", 12'h070, 32'h0);
        tick();
        bus_read("sw_lat2", 12'h070, 32'h005A5A5A);
        bus_write(12'h070, 32'hFFFFFFFF);
        bus_read("sw_ro", 12'h070, 32'h005A5A5A);

        // Digit mask, upper bits ignored.
        bus_write(12'h004, 32'hFFFFFF0F);
        bus_read("rd_mask", 12'h004, 32'h0000000F);
        repeat (32) tick();

        // Unmapped address and idle read.
        bus_write(12'h100, 32'hDEADBEEF);
        bus_read("rd_unmapped", 12'h100, 32'h0);
        bus_read("rd_dig_kept", 12'h000, 32'h1234ABCD);
        bus_read("rd_mask_kept", 12'h004, 32'h0000000F);
        bus_read("rd_led_kept", 12'h060, 32'h00FFFFFF);
        bus.dv_addr = 12'h000;
        bus.dv_rd_e = 1'b0;
        #1;
        check("rd_idle", bus.dv_rd_data, 32'h0);

        // Reset pulse in the middle of digit 5.
        bus_write(12'h004, 32'h000000FF);
        while (((cyc / SCAN_DIV) % 8) != 5) tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dig_en", {24'h0, dig_en}, 32'hFE);
        check("mid_rst_seg", {24'h0, seg}, 32'hC0);
        check("mid_rst_led", 32'(led), 32'h0);
        bus_read("mid_rst_rd_dig", 12'h000, 32'h0);
        bus_read("mid_rst_rd_mask", 12'h004, 32'hFF);
        bus_read("mid_rst_rd_sw", 12'h070, 32'h0);
        #1;
        rst_n  = 1'b1;
        m_dig  = 32'h0;
        m_mask = 8'hFF;
        cyc    = 0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
